tick_wave_gen: RTL and testbench
================================

TICK_WAVE_GEN -- requirements
Module: tick_wave_gen

Interface
REQ-001 SHALL have parameter STEP, default 1, meaning the phase/amplitude increment per accepted tick (legal 1..15).
REQ-002 SHALL have port clk, input, 1 bit: the single clock, rising-edge.
REQ-003 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port init, input, 1 bit: synchronous restart of the waveform.
REQ-005 SHALL have port tick, input, 1 bit: single-cycle rate strobe, driven by the upstream frequency divider's co output.
REQ-006 SHALL have port run, input, 1 bit: when 0, ticks are ignored.
REQ-007 SHALL have port mode, input, 2 bits: 00 square, 01 sawtooth, 10 triangle, 11 sine or square (see Configuration).
REQ-008 SHALL have port wave, output, 8 bits: registered unsigned sample.
REQ-009 SHALL have port strobe, output, 1 bit: high for one cycle when wave has been updated.
REQ-010 SHALL have port wrap, output, 1 bit: high for one cycle when a waveform period completes.

Function
REQ-011 An accepted tick SHALL be tick=1 and run=1 and init=0, sampled on a rising clk edge.
REQ-012 On an accepted tick, the 8-bit phase ph SHALL advance by STEP modulo 256.
REQ-013 wave and strobe SHALL update on the same edge that samples the accepted tick, so they are visible one cycle after tick is asserted; strobe SHALL be 0 on every other cycle.
REQ-014 Square mode: wave SHALL be 8'hFF when ph[7]=1 and 8'h00 otherwise.
REQ-015 Sawtooth mode: wave SHALL equal ph.
REQ-016 Triangle mode SHALL use a 2-state FSM, UP/DOWN, with its own 8-bit level lv.
  - UP: lv+STEP>=255 gives lv=255 and a move to DOWN; otherwise lv+=STEP.
  - DOWN: lv<=STEP gives lv=0 and a move to UP; otherwise lv-=STEP.
  - wave SHALL equal lv.
REQ-017 ph and lv SHALL both advance on every accepted tick regardless of mode, so a mode switch is phase-continuous.
REQ-018 A mode switch SHALL take effect at the next accepted tick; wave SHALL hold its value until then.
REQ-019 wrap SHALL pulse with strobe when either condition holds:
  - ph overflows past 255 in modes 00, 01 and 11;
  - the triangle FSM enters UP from DOWN in mode 10.
REQ-020 init=1 SHALL, at the next edge, do all of the following, and SHALL override a simultaneous tick:
  - clear ph and lv to 0;
  - set the FSM to UP;
  - set wave to 0;
  - set strobe and wrap to 0.
REQ-021 With run=0, all state and wave SHALL hold, and strobe and wrap SHALL be 0.
REQ-022 Arithmetic for lv SHALL use 9 bits internally, so that no wrap-around occurs in triangle mode.

Reset
REQ-023 While rst=1, the block SHALL immediately (asynchronously) set all of the following; the FSM state encoding is the only register not zeroed:
  - ph=0, lv=0, FSM=UP;
  - wave=8'h00, strobe=0, wrap=0.
REQ-024 Reset asserted mid-period SHALL discard all progress; the first accepted tick after release SHALL behave as the first tick after init.

Configuration
REQ-025 Macro TICK_WAVE_SINE_EN SHALL control the sine mode.
  - Defined: mode 11 produces sine from a 64-entry quarter-wave table indexed by ph[5:0], with quadrant taken from ph[7:6].
  - The table value SHALL be 128+round(127*sin(2*pi*ph/256)), so ph=0 gives 128, ph=64 gives 255, ph=128 gives 128, ph=192 gives 1.
  - Not defined: mode 11 SHALL behave exactly as mode 00, and no table logic is present.

Verification
REQ-026 Reset and first tick: rst pulse, then init pulse, then mode=01, STEP=1, run=1, one tick -> wave=1 and strobe=1 one cycle after tick; strobe=0 the following cycle.
REQ-027 Sawtooth wrap: mode=01, STEP=1, 256 ticks -> wave counts 1..255 then 0; wrap=1 only on the tick producing 0.
REQ-028 Triangle: mode=10, STEP=15, repeated ticks -> wave 15,30,...,240,255,240,...,15,0; wrap at the 0 sample; level never exceeds 255.
REQ-029 Priority: tick and init asserted in the same cycle -> wave=0 and strobe=0; run=0 with ticks -> wave holds and strobe stays 0.
REQ-030 Async reset: rst asserted mid-cycle with wave=8'h80 -> wave=0 before the next clk edge.
REQ-031 Mode 11, STEP=64, 4 ticks:
  - with TICK_WAVE_SINE_EN: wave=255, 128, 1, 128;
  - without it: wave=00, FF, FF, 00.

Source files
------------

// File: rtl/tick_wave_gen.sv
// tick_wave_gen: tick-paced waveform generator (square / sawtooth / triangle,
// plus an optional sine mode selected by the TICK_WAVE_SINE_EN macro).
// An 8-bit phase and an independent triangle level advance on every
// accepted tick, so switching mode never loses position in the period.
// Macro TICK_WAVE_SINE_EN: defined -> mode 11 is a quarter-wave sine table;
// undefined -> mode 11 is identical to square and no table is built.
module tick_wave_gen #(
  parameter int unsigned STEP = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       init,
  input  logic       tick,
  input  logic       run,
  input  logic [1:0] mode,
  output logic [7:0] wave,
  output logic       strobe,
  output logic       wrap
);

  localparam logic [8:0] STEP9 = 9'(STEP);
  localparam logic [8:0] LV_MAX = 9'd255;

  // UP is deliberately the non-zero encoding.
  typedef enum logic {
    S_DOWN = 1'b0,
    S_UP   = 1'b1
  } tri_state_t;

  tri_state_t r_state;
  tri_state_t w_state_nxt;

  logic [7:0] r_ph;
  logic [7:0] r_lv;
  logic [7:0] r_wave;
  logic       r_strobe;
  logic       r_wrap;

  logic       w_acc;
  logic [8:0] w_ph_sum;
  logic [7:0] w_ph_nxt;
  logic [8:0] w_lv_up;
  logic [8:0] w_lv_dn;
  logic [7:0] w_lv_nxt;
  logic       w_tri_wrap;
  logic [7:0] w_square;
  logic [7:0] w_wave_nxt;
  logic       w_wrap_nxt;

  assign w_acc    = tick & run & ~init;
  assign w_ph_sum = {1'b0, r_ph} + STEP9;
  assign w_ph_nxt = w_ph_sum[7:0];
  // 9-bit level arithmetic keeps the clamp tests free of wrap-around.
  assign w_lv_up  = {1'b0, r_lv} + STEP9;
  assign w_lv_dn  = {1'b0, r_lv} - STEP9;
  assign w_square = w_ph_nxt[7] ? 8'hFF : 8'h00;

`ifdef TICK_WAVE_SINE_EN
  // round(127*sin(2*pi*i/256)) for i = 0..63; the i = 64 peak (127) is
  // supplied separately since the table only covers a quarter period.
  localparam logic [6:0] QTR [64] = '{
    7'd0,   7'd3,   7'd6,   7'd9,   7'd12,  7'd16,  7'd19,  7'd22,
    7'd25,  7'd28,  7'd31,  7'd34,  7'd37,  7'd40,  7'd43,  7'd46,
    7'd49,  7'd51,  7'd54,  7'd57,  7'd60,  7'd63,  7'd65,  7'd68,
    7'd71,  7'd73,  7'd76,  7'd78,  7'd81,  7'd83,  7'd85,  7'd88,
    7'd90,  7'd92,  7'd94,  7'd96,  7'd98,  7'd100, 7'd102, 7'd104,
    7'd106, 7'd107, 7'd109, 7'd111, 7'd112, 7'd113, 7'd115, 7'd116,
    7'd117, 7'd118, 7'd120, 7'd121, 7'd122, 7'd122, 7'd123, 7'd124,
    7'd125, 7'd125, 7'd126, 7'd126, 7'd126, 7'd127, 7'd127, 7'd127
  };

  logic [5:0] w_q_idx;
  logic [6:0] w_q_mag;
  logic [7:0] w_sine;

  // Odd quadrants read the table mirrored (64 - i); i = 0 there is the peak.
  assign w_q_idx = w_ph_nxt[6] ? (6'd0 - w_ph_nxt[5:0]) : w_ph_nxt[5:0];
  assign w_q_mag = (w_ph_nxt[6] && (w_ph_nxt[5:0] == 6'd0)) ? 7'd127 : QTR[w_q_idx];
  // Upper half of the period sits below mid-scale.
  assign w_sine  = w_ph_nxt[7] ? (8'd128 - {1'b0, w_q_mag})
                               : (8'd128 + {1'b0, w_q_mag});
`endif

  // Triangle FSM next state and level; init forces UP/0 ahead of any tick.
  always_comb begin
    w_state_nxt = r_state;
    w_lv_nxt    = r_lv;
    w_tri_wrap  = 1'b0;
    if (init) begin
      w_state_nxt = S_UP;
      w_lv_nxt    = 8'h00;
    end else if (w_acc) begin
      case (r_state)
        S_UP: begin
          if (w_lv_up >= LV_MAX) begin
            w_lv_nxt    = 8'hFF;
            w_state_nxt = S_DOWN;
          end else begin
            w_lv_nxt = w_lv_up[7:0];
          end
        end
        S_DOWN: begin
          if ({1'b0, r_lv} <= STEP9) begin
            w_lv_nxt    = 8'h00;
            w_state_nxt = S_UP;
            w_tri_wrap  = 1'b1;
          end else begin
            w_lv_nxt = w_lv_dn[7:0];
          end
        end
        default: begin
          w_state_nxt = S_UP;
          w_lv_nxt    = 8'h00;
        end
      endcase
    end
  end

  // Sample selection from the post-tick phase/level, plus period-end flag.
  always_comb begin
    w_wave_nxt = w_square;
    case (mode)
      2'b00: w_wave_nxt = w_square;
      2'b01: w_wave_nxt = w_ph_nxt;
      2'b10: w_wave_nxt = w_lv_nxt;
`ifdef TICK_WAVE_SINE_EN
      2'b11: w_wave_nxt = w_sine;
`else
      2'b11: w_wave_nxt = w_square;
`endif
      default: w_wave_nxt = w_square;
    endcase
    w_wrap_nxt = (mode == 2'b10) ? w_tri_wrap : w_ph_sum[8];
  end

  // Triangle FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_UP;
    else     r_state <= w_state_nxt;
  end

  // Phase, level and registered outputs; strobe/wrap are one-cycle pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ph     <= 8'h00;
      r_lv     <= 8'h00;
      r_wave   <= 8'h00;
      r_strobe <= 1'b0;
      r_wrap   <= 1'b0;
    end else begin
      r_lv <= w_lv_nxt;
      if (init) begin
        r_ph     <= 8'h00;
        r_wave   <= 8'h00;
        r_strobe <= 1'b0;
        r_wrap   <= 1'b0;
      end else if (w_acc) begin
        r_ph     <= w_ph_nxt;
        r_wave   <= w_wave_nxt;
        r_strobe <= 1'b1;
        r_wrap   <= w_wrap_nxt;
      end else begin
        r_strobe <= 1'b0;
        r_wrap   <= 1'b0;
      end
    end
  end

  assign wave   = r_wave;
  assign strobe = r_strobe;
  assign wrap   = r_wrap;

endmodule

// File: tb/tb_tick_wave_gen.sv
// Bench for tick_wave_gen: three instances (STEP = 1, 15, 64) share the
// stimulus; an arithmetic reference model predicts every output.
module tb_tick_wave_gen;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       init = 1'b0;
  logic       tick = 1'b0;
  logic       run = 1'b0;
  logic [1:0] mode = 2'b00;

  logic [7:0] wv [3];
  logic       st [3];
  logic       wr [3];

  int n_pass = 0;
  int n_total = 0;

  int         STEPS [3] = '{1, 15, 64};
  int         m_ph [3];
  int         m_lv [3];
  bit         m_up [3];
  logic [7:0] m_wave [3];
  logic       m_str [3];
  logic       m_wrp [3];

  always #5 clk = ~clk;

  tick_wave_gen #(.STEP(1)) u_dut1 (
    .clk(clk), .rst(rst), .init(init), .tick(tick), .run(run), .mode(mode),
    .wave(wv[0]), .strobe(st[0]), .wrap(wr[0]));
  tick_wave_gen #(.STEP(15)) u_dut15 (
    .clk(clk), .rst(rst), .init(init), .tick(tick), .run(run), .mode(mode),
    .wave(wv[1]), .strobe(st[1]), .wrap(wr[1]));
  tick_wave_gen #(.STEP(64)) u_dut64 (
    .clk(clk), .rst(rst), .init(init), .tick(tick), .run(run), .mode(mode),
    .wave(wv[2]), .strobe(st[2]), .wrap(wr[2]));

  function automatic int sine_ref(input int p);
    real r;
    r = 127.0 * $sin(2.0 * 3.14159265358979 * p / 256.0);
    return 128 + ((r >= 0.0) ? $rtoi(r + 0.5) : -$rtoi(-r + 0.5));
  endfunction

  function automatic logic [7:0] sample(input int k, input logic [1:0] m);
    case (m)
      2'b01: return 8'(m_ph[k]);
      2'b10: return 8'(m_lv[k]);
`ifdef TICK_WAVE_SINE_EN
      2'b11: return 8'(sine_ref(m_ph[k]));
`endif
      default: return (m_ph[k] >= 128) ? 8'hFF : 8'h00;
    endcase
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_ph[k] = 0; m_lv[k] = 0; m_up[k] = 1'b1;
      m_wave[k] = 8'h00; m_str[k] = 1'b0; m_wrp[k] = 1'b0;
    end
  endtask

  // One clock edge of the reference: phase is a modulo counter, the level
  // bounces between 0 and 255 clamped at each end.
  task automatic model_edge(input logic i, input logic t, input logic r,
                            input logic [1:0] m);
    for (int k = 0; k < 3; k++) begin
      int s, np, nl;
      bit ph_ovf, tri_wrap;
      m_str[k] = 1'b0;
      m_wrp[k] = 1'b0;
      if (i) begin
        m_ph[k] = 0; m_lv[k] = 0; m_up[k] = 1'b1; m_wave[k] = 8'h00;
      end else if (t && r) begin
        s = STEPS[k];
        np = m_ph[k] + s;
        ph_ovf = (np > 255);
        m_ph[k] = np % 256;
        nl = m_up[k] ? m_lv[k] + s : m_lv[k] - s;
        tri_wrap = 1'b0;
        if (m_up[k] && nl >= 255) begin
          nl = 255; m_up[k] = 1'b0;
        end else if (!m_up[k] && nl <= 0) begin
          nl = 0; m_up[k] = 1'b1; tri_wrap = 1'b1;
        end
        m_lv[k] = nl;
        m_wave[k] = sample(k, m);
        m_str[k] = 1'b1;
        m_wrp[k] = (m == 2'b10) ? tri_wrap : ph_ovf;
      end
    end
  endtask

  // Drive one cycle of inputs, advance the model at the edge, settle 1ns.
  task automatic drive(input logic i, input logic t, input logic r,
                       input logic [1:0] m);
    @(negedge clk);
    init = i; tick = t; run = r; mode = m;
    @(posedge clk);
    model_edge(i, t, r, m);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #3;
    model_reset();
    for (int k = 0; k < 3; k++) begin
      n_total++;
      if ({wv[k], st[k], wr[k]} !== 10'b0) $display("FAIL reset inst%0d wave=%h strobe=%b wrap=%b required 00/0/0", k, wv[k], st[k], wr[k]);
      else n_pass++;
    end
    @(negedge clk);
    rst = 1'b0;
    drive(1, 0, 1, 2'b01);
  endtask

  task automatic test_first_tick();
    drive(1, 0, 1, 2'b01);
    drive(0, 1, 1, 2'b01);
    n_total++;
    if (wv[0] !== 8'd1 || st[0] !== 1'b1) $display("FAIL first_tick wave=%h strobe=%b required 01/1", wv[0], st[0]);
    else n_pass++;
    drive(0, 0, 1, 2'b01);
    n_total++;
    if (wv[0] !== 8'd1 || st[0] !== 1'b0) $display("FAIL first_tick_after wave=%h strobe=%b required 01/0", wv[0], st[0]);
    else n_pass++;
  endtask

  task automatic test_saw_wrap();
    int bad;
    bad = 0;
    drive(1, 0, 1, 2'b01);
    for (int i = 1; i <= 256; i++) begin
      drive(0, 1, 1, 2'b01);
      if (wv[0] !== 8'(i % 256) || st[0] !== 1'b1 || wr[0] !== (i == 256)) begin
        if (bad == 0) $display("FAIL saw_wrap tick%0d wave=%h wrap=%b required %h/%b", i, wv[0], wr[0], 8'(i % 256), (i == 256));
        bad++;
      end
      for (int k = 1; k < 3; k++)
        if (wv[k] !== m_wave[k] || wr[k] !== m_wrp[k]) begin
          if (bad == 0) $display("FAIL saw_model inst%0d tick%0d wave=%h wrap=%b required %h/%b", k, i, wv[k], wr[k], m_wave[k], m_wrp[k]);
          bad++;
        end
    end
    n_total++;
    if (bad != 0) $display("FAIL saw_wrap_total errors=%0d required 0", bad);
    else n_pass++;
  endtask

  task automatic test_triangle();
    int exp_seq [$];
    int bad;
    bad = 0;
    for (int j = 1; j <= 16; j++) exp_seq.push_back(15 * j);
    exp_seq.push_back(255);
    for (int j = 1; j <= 16; j++) exp_seq.push_back(255 - 15 * j);
    exp_seq.push_back(0);
    drive(1, 0, 1, 2'b10);
    for (int i = 0; i < exp_seq.size(); i++) begin
      drive(0, 1, 1, 2'b10);
      if (wv[1] !== 8'(exp_seq[i]) || wr[1] !== (i == exp_seq.size() - 1)) begin
        if (bad == 0) $display("FAIL triangle tick%0d wave=%0d wrap=%b required %0d/%b", i + 1, wv[1], wr[1], exp_seq[i], (i == exp_seq.size() - 1));
        bad++;
      end
    end
    n_total++;
    if (bad != 0) $display("FAIL triangle_total errors=%0d required 0", bad);
    else n_pass++;
    drive(0, 1, 1, 2'b10);
    n_total++;
    if (wv[1] !== 8'd15 || wr[1] !== 1'b0) $display("FAIL triangle_restart wave=%0d wrap=%b required 15/0", wv[1], wr[1]);
    else n_pass++;
  endtask

  task automatic test_priority();
    drive(1, 0, 1, 2'b01);
    drive(0, 1, 1, 2'b01);
    drive(0, 1, 1, 2'b01);
    drive(1, 1, 1, 2'b01);
    n_total++;
    if (wv[0] !== 8'h00 || st[0] !== 1'b0) $display("FAIL init_over_tick wave=%h strobe=%b required 00/0", wv[0], st[0]);
    else n_pass++;
    drive(0, 1, 1, 2'b01);
    drive(0, 1, 1, 2'b01);
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 0, 2'b01);
      n_total++;
      if (wv[0] !== 8'd2 || st[0] !== 1'b0 || wr[0] !== 1'b0) $display("FAIL run_low_hold wave=%h strobe=%b required 02/0", wv[0], st[0]);
      else n_pass++;
    end
    // Mode change without a tick leaves the sample alone.
    drive(0, 0, 1, 2'b00);
    n_total++;
    if (wv[0] !== 8'd2) $display("FAIL mode_hold wave=%h required 02", wv[0]);
    else n_pass++;
    drive(0, 1, 1, 2'b00);
    n_total++;
    if (wv[0] !== 8'h00 || st[0] !== 1'b1) $display("FAIL mode_switch wave=%h strobe=%b required 00/1", wv[0], st[0]);
    else n_pass++;
  endtask

  task automatic test_async_reset();
    drive(1, 0, 1, 2'b01);
    for (int i = 0; i < 128; i++) drive(0, 1, 1, 2'b01);
    n_total++;
    if (wv[0] !== 8'h80) $display("FAIL pre_reset wave=%h required 80", wv[0]);
    else n_pass++;
    @(negedge clk);
    tick = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    n_total++;
    if (wv[0] !== 8'h00) $display("FAIL async_reset wave=%h required 00", wv[0]);
    else n_pass++;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    drive(0, 1, 1, 2'b01);
    n_total++;
    if (wv[0] !== 8'd1 || st[0] !== 1'b1 || wv[1] !== 8'd15) $display("FAIL post_reset_tick wave=%h/%h strobe=%b required 01/0f/1", wv[0], wv[1], st[0]);
    else n_pass++;
  endtask

  task automatic test_mode11();
`ifdef TICK_WAVE_SINE_EN
    logic [7:0] exp_w [4] = '{8'd255, 8'd128, 8'd1, 8'd128};
`else
    logic [7:0] exp_w [4] = '{8'h00, 8'hFF, 8'hFF, 8'h00};
`endif
    drive(1, 0, 1, 2'b11);
    for (int i = 0; i < 4; i++) begin
      drive(0, 1, 1, 2'b11);
      n_total++;
      if (wv[2] !== exp_w[i] || wr[2] !== (i == 3)) $display("FAIL mode11 tick%0d wave=%h wrap=%b required %h/%b", i + 1, wv[2], wr[2], exp_w[i], (i == 3));
      else n_pass++;
    end
  endtask

  task automatic test_random();
    int bad;
    bad = 0;
    for (int c = 0; c < 1500; c++) begin
      drive(($urandom_range(0, 49) == 0), $urandom_range(0, 1), ($urandom_range(0, 4) != 0),
            2'($urandom_range(0, 3)));
      for (int k = 0; k < 3; k++)
        if (wv[k] !== m_wave[k] || st[k] !== m_str[k] || wr[k] !== m_wrp[k]) begin
          if (bad < 5) $display("FAIL random cyc%0d inst%0d wave=%h strobe=%b wrap=%b required %h/%b/%b", c, k, wv[k], st[k], wr[k], m_wave[k], m_str[k], m_wrp[k]);
          bad++;
        end
    end
    n_total++;
    if (bad != 0) $display("FAIL random_total errors=%0d required 0", bad);
    else n_pass++;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_first_tick();
    test_saw_wrap();
    test_triangle();
    test_priority();
    test_async_reset();
    test_mode11();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
